ysyx_wb_unit: RTL

Write-back unit for the NPC core. It is the single writer for the register file's write port (`rf_wr_en`/`waddr`/`wdata`) and arbitrates between single-cycle ALU results and out-of-order-arriving load results buffered in a small FIFO. A per-register pending scoreboard tracks issued loads so decode can stall on RAW hazards. Sits between execute/LSU and the register file.

---
 rtl/ysyx_wb_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_wb_unit.sv
// ysyx_wb_unit: write-back stage for the NPC core.
// It is the only writer of the register file write port. Each cycle it picks
// one of two sources: the ALU result, which is offered for a single cycle, or
// the oldest buffered load result. A per-register pending scoreboard lets
// decode stall on loads that have not yet written back.
// Optional build macro YSYX_WB_TRACE_EN: prints every committed write
// (source, address, data) in simulation. With the macro undefined the unit
// produces no simulation output.
module ysyx_wb_unit #(
  parameter int XLEN       = 32,
  parameter int LQ_DEPTH   = 2,
  parameter int STREAK_MAX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      busy_raddr1,
  input  logic [4:0]      busy_raddr2,
  output logic            busy1,
  output logic            busy2,
  output logic            rf_wr_en,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);

  localparam int AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = (STREAK_MAX > 0) ? $clog2(STREAK_MAX + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] STREAK_C = SW'(STREAK_MAX);

  // Load-result queue storage (no reset needed: occupancy is tracked separately)
  logic [4:0]      q_rd_mem   [LQ_DEPTH];
  logic [XLEN-1:0] q_data_mem [LQ_DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [SW-1:0] streak_reg;
  logic [SW-1:0] streak_next;

  logic            rf_wr_en_reg;
  logic [4:0]      waddr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            from_lsu_reg;

  logic fifo_empty;
  logic push;
  logic pop_sel;
  logic alu_sel;

  logic [31:0] pending;

  // Arbitration: the queue wins unless the ALU has been waiting for too long
  always_comb begin
    fifo_empty = (count_reg == '0);
    lsu_ready  = (count_reg < DEPTH_C);
    push       = lsu_valid && lsu_ready;
    pop_sel    = !fifo_empty && (!alu_valid || (streak_reg < STREAK_C));
    alu_sel    = alu_valid && !pop_sel;
    alu_ready  = alu_sel;
  end

  // Streak of queue wins while the ALU was kept waiting
  always_comb begin
    streak_next = streak_reg;
    if (!alu_valid) begin
      streak_next = '0;
    end else if (pop_sel) begin
      streak_next = streak_reg + SW'(1);
    end else begin
      streak_next = '0;
    end
  end

  // Queue storage write
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_mem[wr_ptr_reg]   <= lsu_rd;
      q_data_mem[wr_ptr_reg] <= lsu_data;
    end
  end

  // Queue pointers, occupancy and streak counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_sel) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop_sel})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output slot: load the winner; writes to x0 consume the slot without enabling the RF
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en_reg <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      from_lsu_reg <= 1'b0;
    end else if (pop_sel) begin
      rf_wr_en_reg <= (q_rd_mem[rd_ptr_reg] != 5'd0);
      waddr_reg    <= q_rd_mem[rd_ptr_reg];
      wdata_reg    <= q_data_mem[rd_ptr_reg];
      from_lsu_reg <= 1'b1;
    end else if (alu_sel) begin
      rf_wr_en_reg <= (alu_rd != 5'd0);
      waddr_reg    <= alu_rd;
      wdata_reg    <= alu_data;
      from_lsu_reg <= 1'b0;
    end else begin
      rf_wr_en_reg <= 1'b0;
    end
  end

  assign rf_wr_en = rf_wr_en_reg;
  assign waddr    = waddr_reg;
  assign wdata    = wdata_reg;

  // x0 can never be pending
  assign pending[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      logic pend_reg;
      // Set on load issue (takes priority), clear when the load's write commits
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= 1'b0;
        end else if (issue_valid && (issue_rd == 5'(gi))) begin
          pend_reg <= 1'b1;
        end else if (rf_wr_en_reg && from_lsu_reg && (waddr_reg == 5'(gi))) begin
          pend_reg <= 1'b0;
        end
      end
      assign pending[gi] = pend_reg;
    end
  endgenerate

  assign busy1 = pending[busy_raddr1];
  assign busy2 = pending[busy_raddr2];

`ifdef YSYX_WB_TRACE_EN
  // Trace every write committed to the register file
  always_ff @(posedge clk) begin
    if (!rst && rf_wr_en_reg) begin
      $display("wb %s x%0d = 0x%h", from_lsu_reg ? "LSU" : "ALU", waddr_reg, wdata_reg);
    end
  end
`else
  // Silent build: no simulation output.
`endif

endmodule
